// File: rtl/psum_accum_relu.sv
// rtl/psum_accum_relu.sv - psum scatter/accumulate buffer with ReLU writeback; optional saturating adds under PSUM_SAT_EN
module psum_accum_relu #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ker     = 3,
    parameter int in_w    = 6,
    parameter int out_w   = 4,
    parameter int addr_bw = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [addr_bw-1:0]        base_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [col*psum_bw-1:0]    in_data,
    output logic                      sram_cen,
    output logic                      sram_wen,
    output logic [addr_bw-1:0]        sram_a,
    output logic [col*psum_bw-1:0]    sram_d,
    output logic                      busy,
    output logic                      done
);

    localparam int dw       = col * psum_bw;
    localparam int len_onij = out_w * out_w;
    localparam int kw       = $clog2(ker);
    localparam int pw       = $clog2(in_w);
    localparam int hw       = $clog2(out_w);
    localparam int ow       = $clog2(len_onij);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // kij is tracked as (ki, kj) and nij as (r, c) so the window test needs no division
    logic [kw-1:0]      ki, kj;
    logic [pw-1:0]      r, c;
    logic [ow-1:0]      wcnt, nxt_o;
    logic [addr_bw-1:0] base;
    logic [dw-1:0]      acc_buf [len_onij];

    logic [pw-1:0]      dr, dc;
    logic               hit, accept, last_word;
    logic [ow-1:0]      onij;
    logic [dw-1:0]      upd, first_src;

    function automatic logic [psum_bw-1:0] lane_add(input logic [psum_bw-1:0] a,
                                                     input logic [psum_bw-1:0] b);
`ifdef PSUM_SAT_EN
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            lane_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        else
            lane_add = s[psum_bw-1:0];
`else
        lane_add = a + b;
`endif
    endfunction

    function automatic logic [dw-1:0] relu(input logic [dw-1:0] w);
        relu = w;
        for (int k = 0; k < col; k++)
            if (w[k*psum_bw + psum_bw - 1]) relu[k*psum_bw +: psum_bw] = '0;
    endfunction

    assign in_ready = (state == ST_ACCUM);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign accept   = in_valid && in_ready;
    assign nxt_o    = wcnt + 1'b1;

    // Map the current (kij, nij) onto an output pixel, or flag it as outside the window
    always_comb begin
        dr        = r - pw'(ki);
        dc        = c - pw'(kj);
        hit       = (r >= pw'(ki)) && (dr < pw'(out_w)) && (c >= pw'(kj)) && (dc < pw'(out_w));
        onij      = {dr[hw-1:0], dc[hw-1:0]};
        last_word = (ki == kw'(ker-1)) && (kj == kw'(ker-1)) &&
                    (r == pw'(in_w-1)) && (c == pw'(in_w-1));
    end

    // Lane-wise sum of the targeted entry and the incoming word; entry 0 bypass feeds the first write
    always_comb begin
        upd = '0;
        for (int k = 0; k < col; k++)
            upd[k*psum_bw +: psum_bw] = lane_add(acc_buf[onij][k*psum_bw +: psum_bw],
                                                 in_data[k*psum_bw +: psum_bw]);
        first_src = (hit && (onij == '0)) ? upd : acc_buf[0];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ACCUM;
            ST_ACCUM: if (accept && last_word) state_nxt = ST_WRITE;
            ST_WRITE: if (wcnt == ow'(len_onij-1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Counters, accumulation buffer and registered SRAM write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ki       <= '0;
            kj       <= '0;
            r        <= '0;
            c        <= '0;
            wcnt     <= '0;
            base     <= '0;
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            sram_a   <= '0;
            sram_d   <= '0;
            for (int i = 0; i < len_onij; i++) acc_buf[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < len_onij; i++) acc_buf[i] <= '0;
                        base <= base_addr;
                        ki   <= '0;
                        kj   <= '0;
                        r    <= '0;
                        c    <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (hit) acc_buf[onij] <= upd;
                        if (c == pw'(in_w-1)) begin
                            c <= '0;
                            if (r == pw'(in_w-1)) begin
                                r <= '0;
                                if (kj == kw'(ker-1)) begin
                                    kj <= '0;
                                    ki <= ki + 1'b1;
                                end else begin
                                    kj <= kj + 1'b1;
                                end
                            end else begin
                                r <= r + 1'b1;
                            end
                        end else begin
                            c <= c + 1'b1;
                        end
                        // The first write goes out in the cycle right after the final accept
                        if (last_word) begin
                            wcnt     <= '0;
                            sram_cen <= 1'b0;
                            sram_wen <= 1'b0;
                            sram_a   <= base;
                            sram_d   <= relu(first_src);
                        end
                    end
                end
                ST_WRITE: begin
                    if (wcnt == ow'(len_onij-1)) begin
                        sram_cen <= 1'b1;
                        sram_wen <= 1'b1;
                    end else begin
                        wcnt   <= nxt_o;
                        sram_a <= base + addr_bw'(nxt_o);
                        sram_d <= relu(acc_buf[nxt_o]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_relu.sv
// tb/tb_psum_accum_relu.sv - randomized self-checking bench for psum_accum_relu
`timescale 1ns/1ps
module tb_psum_accum_relu;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DW  = COL * BW;
    localparam int NW  = 324;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [6:0]    base_addr = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, sram_cen, sram_wen, busy, done;
    logic [6:0]    sram_a;
    logic [DW-1:0] sram_d;

    always #5 clk = ~clk;

    psum_accum_relu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .busy      (busy),
        .done      (done)
    );

    logic [DW-1:0] words [NW];
    logic [DW-1:0] exp_d [16];
    logic [6:0]    exp_a [16];

    // monitor-owned state
    int passed = 0, total = 0;
    int cyc = 0, acc_cnt = 0, widx = 0, done_cnt = 0, last_acc_cyc = 0, last_wr_cyc = 0;
    int seen_seq = 0, req_seen = 0;
    bit layer_done = 1'b0;

    // driver-owned state
    int layer_seq = 0, req_seq = 0;
    bit active = 1'b0;
    string req_name = "";
    logic [DW-1:0] req_act = '0, req_exp = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic post(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        req_name = name;
        req_act  = act;
        req_exp  = exp;
        req_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] add_lane(input logic [BW-1:0] a, input logic [BW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return BW'(s);
    endfunction

    // Gather view: each output pixel sums the 9 input pixels under its kernel window
    function automatic void build_expect(input logic [6:0] base);
        for (int o = 0; o < 16; o++) begin
            int oi, oj;
            logic [DW-1:0] w;
            oi = o / 4;
            oj = o % 4;
            w  = '0;
            for (int l = 0; l < COL; l++) begin
                logic [BW-1:0] acc;
                acc = '0;
                for (int kij = 0; kij < 9; kij++) begin
                    int nij;
                    nij = (oi + kij / 3) * 6 + oj + kij % 3;
                    acc = add_lane(acc, words[kij*36 + nij][l*BW +: BW]);
                end
                w[l*BW +: BW] = acc[BW-1] ? '0 : acc;
            end
            exp_d[o] = w;
            exp_a[o] = base + 7'(o);
        end
    endfunction

    task automatic fill_const(input logic [BW-1:0] v);
        for (int i = 0; i < NW; i++) words[i] = {COL{v}};
    endtask

    always @(negedge clk) begin
        cyc++;
        if (seen_seq != layer_seq) begin
            seen_seq   = layer_seq;
            acc_cnt    = 0;
            widx       = 0;
            layer_done = 1'b0;
        end
        if (req_seen != req_seq) begin
            req_seen = req_seq;
            chk(req_name, req_act, req_exp);
        end
        if (!reset) begin
            chk("rst_cen", sram_cen, 1);
            chk("rst_wen", sram_wen, 1);
            chk("rst_a", sram_a, 0);
            chk("rst_d", sram_d, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ready", in_ready, 0);
        end else if (active && !layer_done) begin
            chk("in_ready", in_ready, acc_cnt < NW);
            chk("busy", busy, 1);
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (!sram_cen) begin
                chk("wr_wen", sram_wen, 0);
                if (widx == 0) chk("first_write_lat", cyc - last_acc_cyc, 1);
                if (widx < 16) begin
                    chk("wr_addr", sram_a, exp_a[widx]);
                    chk("wr_data", sram_d, exp_d[widx]);
                end else begin
                    chk("extra_write", widx, 15);
                end
                widx++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                chk("writes_before_done", widx, 16);
                chk("done_lat", cyc - last_wr_cyc, 1);
                done_cnt++;
                layer_done = 1'b1;
            end
        end else begin
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_cen", sram_cen, 1);
        end
    end

    task automatic run_layer(input logic [6:0] base, input bit gaps, input int pre_idle,
                             input int start_at, input int abort_at, input int abort_wr);
        int i, guard, dc0;
        bit acc, sent, aborted;
        i = 0; guard = 0; sent = 1'b0; aborted = 1'b0;
        dc0 = done_cnt;
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 7'($urandom);
        layer_seq++;
        active = 1'b1;
        repeat (pre_idle) begin @(posedge clk); #1; end
        while (i < NW && guard < 4000 && !aborted) begin
            if (i == abort_at) begin
                active = 1'b0;
                reset = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                aborted = 1'b1;
            end else begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data = words[i];
                start = (i == start_at) && !sent;
                if (start) sent = 1'b1;
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (acc) i++;
                guard++;
            end
        end
        in_valid = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        guard = 0;
        while (!layer_done && !aborted && guard < 100) begin
            if (abort_wr >= 0 && widx >= abort_wr) begin
                active = 1'b0;
                reset = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
                guard++;
            end
        end
        post("layer_end", layer_done || aborted, 1);
        active = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        post("done_count", done_cnt - dc0, aborted ? 0 : 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // start with no input for a while, then all ones at base 0
        fill_const(16'h0001);
        build_expect(7'd0);
        post("pin_ones", exp_d[0], {COL{16'h0009}});
        run_layer(7'd0, 1'b0, 40, -1, -1, -1);

        // all -1: ReLU clears every lane
        fill_const(16'hFFFF);
        build_expect(7'd64);
        post("pin_neg", exp_d[7], '0);
        post("pin_addr79", exp_a[15], 7'd79);
        run_layer(7'd64, 1'b0, 0, -1, -1, -1);

        // sparse words; base near the top of the address space so addresses wrap
        fill_const(16'h0000);
        words[4*36 + 7][15:0]   = 16'd5;
        words[0*36 + 35][63:48] = 16'd2;
        words[8*36 + 35][63:48] = 16'd3;
        build_expect(7'd120);
        post("pin_sparse0", exp_d[0], 128'd5);
        post("pin_sparse15", exp_d[15], 128'd3 << 48);
        post("pin_wrap_addr", exp_a[15], 7'd7);
        run_layer(7'd120, 1'b0, 0, -1, -1, -1);

        // gaps plus an ignored start pulse mid-layer
        fill_const(16'h0001);
        build_expect(7'd33);
        run_layer(7'd33, 1'b1, 0, 100, -1, -1);

        // reset mid-ACCUM, then a fresh layer
        run_layer(7'd10, 1'b1, 0, -1, 150, -1);
        build_expect(7'd3);
        run_layer(7'd3, 1'b1, 2, -1, -1, -1);

        // reset mid-WRITE, then a fresh layer
        build_expect(7'd90);
        run_layer(7'd90, 1'b0, 0, -1, -1, 5);
        run_layer(7'd90, 1'b0, 0, -1, -1, -1);

        // fully random words
        for (int i = 0; i < NW; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
        build_expect(7'd50);
        run_layer(7'd50, 1'b1, 0, -1, -1, -1);

        // overflow behaviour
        fill_const(16'h7000);
        build_expect(7'd20);
`ifdef PSUM_SAT_EN
        post("pin_sat", exp_d[5], {COL{16'h7FFF}});
`else
        post("pin_wrap", exp_d[5], '0);
`endif
        run_layer(7'd20, 1'b1, 0, -1, -1, -1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
